// File: rtl/instruction_fetch_unit.sv
// Fetch stage: holds the PC, issues instruction-memory reads on fetch, and applies jump/branch redirects.
// Optional WAIT timeout is compiled in with `define FETCH_TIMEOUT_EN.
module instruction_fetch_unit #(
  parameter int                    PC_WIDTH       = 10,
  parameter int                    INSTR_WIDTH    = 20,
  parameter logic [PC_WIDTH-1:0]   RESET_PC       = '0,
  parameter int                    TIMEOUT_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   fetch,
  input  logic                   pc_load,
  input  logic [PC_WIDTH-1:0]    pc_target,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  input  logic                   imem_valid,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic                   instr_valid,
  output logic [PC_WIDTH-1:0]    pc,
  output logic                   pc_overflow,
  output logic                   busy,
  output logic                   fetch_timeout
);

  typedef enum logic [1:0] {IDLE, WAIT, HALT} state_t;

  localparam logic [PC_WIDTH-1:0] PC_MAX = '1;

  state_t                 state, state_nxt;
  logic [PC_WIDTH-1:0]    pc_nxt, addr_nxt, redir, redir_nxt;
  logic                   redir_vld, redir_vld_nxt;
  logic [INSTR_WIDTH-1:0] instr_nxt;
  logic                   valid_nxt, ovf_nxt, tmo_nxt;
  logic                   tmo_hit;

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;
  logic             tmo_q;

  // Counter idles at zero outside WAIT, so it is clear on every entry.
  always_ff @(posedge clk) begin
    if (!rst_n || state != WAIT) wait_cnt <= '0;
    else                         wait_cnt <= wait_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) tmo_q <= 1'b0;
    else        tmo_q <= tmo_nxt;
  end

  assign tmo_hit       = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign fetch_timeout = tmo_q;
`else
  assign tmo_hit       = 1'b0;
  assign fetch_timeout = 1'b0;
`endif

  assign imem_req = (state == WAIT);
  assign busy     = (state != IDLE);

  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    addr_nxt      = imem_addr;
    redir_nxt     = redir;
    redir_vld_nxt = redir_vld;
    instr_nxt     = instruction;
    valid_nxt     = 1'b0;
    ovf_nxt       = pc_overflow;
    tmo_nxt       = fetch_timeout;
    case (state)
      IDLE: begin
        if (fetch) begin
          addr_nxt      = pc_load ? pc_target : pc;
          redir_vld_nxt = 1'b0;
          state_nxt     = WAIT;
        end else if (pc_load) begin
          pc_nxt = pc_target;
        end
      end
      WAIT: begin
        if (imem_valid) begin
          instr_nxt     = imem_rdata;
          valid_nxt     = 1'b1;
          redir_vld_nxt = 1'b0;
          state_nxt     = IDLE;
          // A redirect arriving with the data still wins over the increment.
          if (pc_load)        pc_nxt = pc_target;
          else if (redir_vld) pc_nxt = redir;
          else begin
            pc_nxt = imem_addr + PC_WIDTH'(1);
            if (imem_addr == PC_MAX) begin
              ovf_nxt   = 1'b1;
              state_nxt = HALT;
            end
          end
        end else begin
          if (pc_load) begin
            redir_vld_nxt = 1'b1;
            redir_nxt     = pc_target;
          end
          if (tmo_hit) begin
            tmo_nxt   = 1'b1;
            state_nxt = HALT;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      imem_addr   <= '0;
      redir       <= '0;
      redir_vld   <= 1'b0;
      instruction <= '0;
      instr_valid <= 1'b0;
      pc_overflow <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      imem_addr   <= addr_nxt;
      redir       <= redir_nxt;
      redir_vld   <= redir_vld_nxt;
      instruction <= instr_nxt;
      instr_valid <= valid_nxt;
      pc_overflow <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: a transaction-level model is checked every cycle,
// and literal expectations at key points pin the model.
module tb_instruction_fetch_unit;
  localparam int PW = 10;
  localparam int IW = 20;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          rst_n, fetch, pc_load, imem_valid;
  logic [PW-1:0] pc_target;
  logic [IW-1:0] imem_rdata;
  logic          imem_req, instr_valid, pc_overflow, busy, fetch_timeout;
  logic [PW-1:0] imem_addr, pc;
  logic [IW-1:0] instruction;

  int n_cmp = 0;
  int n_bad = 0;

  instruction_fetch_unit #(.PC_WIDTH(PW), .INSTR_WIDTH(IW), .RESET_PC('0), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .fetch(fetch), .pc_load(pc_load), .pc_target(pc_target),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid), .imem_req(imem_req), .imem_addr(imem_addr),
    .instruction(instruction), .instr_valid(instr_valid), .pc(pc), .pc_overflow(pc_overflow),
    .busy(busy), .fetch_timeout(fetch_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: mode 0 = idle, 1 = memory read outstanding, 2 = halted.
  int m_mode, m_pc, m_addr, m_instr, m_redir, m_waits;
  bit m_vld, m_ovf, m_tmo, m_has_redir;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_mode = 0; m_pc = 0; m_addr = 0; m_instr = 0; m_redir = 0; m_waits = 0;
      m_vld = 0; m_ovf = 0; m_tmo = 0; m_has_redir = 0;
    end else begin
      m_vld = 0;
      if (m_mode == 0) begin
        if (fetch) begin
          m_addr = pc_load ? int'(pc_target) : m_pc;
          m_mode = 1; m_waits = 0; m_has_redir = 0;
        end else if (pc_load) m_pc = int'(pc_target);
      end else if (m_mode == 1) begin
        if (imem_valid) begin
          m_instr = int'(imem_rdata); m_vld = 1; m_mode = 0;
          if (pc_load) m_pc = int'(pc_target);
          else if (m_has_redir) m_pc = m_redir;
          else begin
            m_pc = (m_addr + 1) % (1 << PW);
            if (m_addr == (1 << PW) - 1) begin m_ovf = 1; m_mode = 2; end
          end
          m_has_redir = 0;
        end else begin
          if (pc_load) begin m_has_redir = 1; m_redir = int'(pc_target); end
          m_waits++;
`ifdef FETCH_TIMEOUT_EN
          if (m_waits == TMO) begin m_tmo = 1; m_mode = 2; end
`endif
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    chk("m_req",   32'(imem_req),      32'(m_mode == 1));
    chk("m_busy",  32'(busy),          32'(m_mode != 0));
    chk("m_pc",    32'(pc),            32'(m_pc));
    chk("m_addr",  32'(imem_addr),     32'(m_addr));
    chk("m_instr", 32'(instruction),   32'(m_instr));
    chk("m_vld",   32'(instr_valid),   32'(m_vld));
    chk("m_ovf",   32'(pc_overflow),   32'(m_ovf));
    chk("m_tmo",   32'(fetch_timeout), 32'(m_tmo));
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  initial begin
    rst_n = 0; fetch = 0; pc_load = 0; pc_target = '0; imem_valid = 0; imem_rdata = '0;
    step(); step();
    chk("rst_pc", 32'(pc), 0); chk("rst_busy", 32'(busy), 0); chk("rst_req", 32'(imem_req), 0);
    rst_n = 1; step();

    // zero-wait fetch at address 0
    fetch = 1; step();
    chk("t1_req", 32'(imem_req), 1); chk("t1_addr", 32'(imem_addr), 0);
    fetch = 0; imem_valid = 1; imem_rdata = 20'hABCDE; step();
    imem_valid = 0;
    chk("t1_instr", 32'(instruction), 32'h ABCDE); chk("t1_vld", 32'(instr_valid), 1);
    chk("t1_pc", 32'(pc), 1); chk("t1_req0", 32'(imem_req), 0);

    // back-to-back fetch, 5-cycle memory, fetch held during WAIT
    fetch = 1; step();
    for (int k = 0; k < 5; k++) begin
      chk("t2_req", 32'(imem_req), 1); chk("t2_addr", 32'(imem_addr), 1);
      if (k == 4) begin fetch = 0; imem_valid = 1; imem_rdata = 20'h12345; end
      step();
    end
    imem_valid = 0;
    chk("t2_instr", 32'(instruction), 32'h12345); chk("t2_vld", 32'(instr_valid), 1);
    chk("t2_pc", 32'(pc), 2); chk("t2_req0", 32'(imem_req), 0);
    step();
    chk("t2_vld0", 32'(instr_valid), 0); chk("t2_noreq", 32'(imem_req), 0);

    // redirect during WAIT, then fetch+pc_load in IDLE
    fetch = 1; step();
    fetch = 0; pc_load = 1; pc_target = 10'h155; step();
    pc_load = 0; step();
    imem_valid = 1; imem_rdata = 20'h0F0F0; step();
    imem_valid = 0;
    chk("t3_pc", 32'(pc), 32'h155); chk("t3_instr", 32'(instruction), 32'h0F0F0);
    fetch = 1; pc_load = 1; pc_target = 10'h020; step();
    fetch = 0; pc_load = 0;
    chk("t3_addr", 32'(imem_addr), 32'h020);
    imem_valid = 1; imem_rdata = 20'h55555; step();
    imem_valid = 0;
    chk("t3_pc2", 32'(pc), 32'h021);

    // overflow at 0x3FF -> HALT
    pc_load = 1; pc_target = 10'h3FF; step();
    pc_load = 0;
    chk("t4_pc", 32'(pc), 32'h3FF);
    fetch = 1; step();
    fetch = 0;
    chk("t4_addr", 32'(imem_addr), 32'h3FF);
    imem_valid = 1; imem_rdata = 20'hFFFFF; step();
    imem_valid = 0;
    chk("t4_pc0", 32'(pc), 0); chk("t4_ovf", 32'(pc_overflow), 1);
    chk("t4_busy", 32'(busy), 1); chk("t4_vld", 32'(instr_valid), 1);
    fetch = 1; pc_load = 1; pc_target = 10'h005;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t4_halt_req", 32'(imem_req), 0); chk("t4_halt_pc", 32'(pc), 0);
      chk("t4_halt_busy", 32'(busy), 1);
    end
    fetch = 0; pc_load = 0;

    // reset exits HALT; reset during WAIT aborts; stale valid ignored
    rst_n = 0; step();
    rst_n = 1;
    chk("t5_ovf", 32'(pc_overflow), 0); chk("t5_busy", 32'(busy), 0);
    fetch = 1; step();
    fetch = 0;
    chk("t5_req", 32'(imem_req), 1);
    step();
    rst_n = 0; step();
    rst_n = 1;
    chk("t5_req0", 32'(imem_req), 0); chk("t5_addr", 32'(imem_addr), 0);
    chk("t5_instr", 32'(instruction), 0); chk("t5_busy0", 32'(busy), 0);
    imem_valid = 1; imem_rdata = 20'h11111; step();
    imem_valid = 0;
    chk("t5_stale_vld", 32'(instr_valid), 0); chk("t5_stale_instr", 32'(instruction), 0);
    chk("t5_stale_pc", 32'(pc), 0);

    // memory that never answers
    fetch = 1; step();
    fetch = 0;
`ifdef FETCH_TIMEOUT_EN
    for (int k = 0; k < TMO; k++) begin
      chk("t6_req", 32'(imem_req), 1); chk("t6_tmo0", 32'(fetch_timeout), 0);
      step();
    end
    chk("t6_tmo", 32'(fetch_timeout), 1); chk("t6_req0", 32'(imem_req), 0);
    chk("t6_pc", 32'(pc), 0); chk("t6_vld", 32'(instr_valid), 0);
    chk("t6_busy", 32'(busy), 1);
`else
    repeat (20) step();
    chk("t6_tmo", 32'(fetch_timeout), 0); chk("t6_req", 32'(imem_req), 1);
    imem_valid = 1; imem_rdata = 20'h2468A; step();
    imem_valid = 0;
    chk("t6_vld", 32'(instr_valid), 1); chk("t6_pc", 32'(pc), 1);
    chk("t6_instr", 32'(instruction), 32'h2468A);
`endif
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
